// File: rtl/l2_sq_accum_param.sv
// Streaming sum-of-squares engine with vector framing, configurable multiplier
// pipeline depth and wrap/saturate overflow handling.
module l2_sq_accum_param #(
  parameter int unsigned WIDTH_IN    = 8,
  parameter int unsigned WIDTH_ACC   = 20,
  parameter int unsigned MULT_STAGES = 1,
  parameter int unsigned SATURATE    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH_IN-1:0]  a,
  input  logic                 valid_in,
  input  logic                 last_in,
  output logic [WIDTH_ACC-1:0] f,
  output logic                 valid_out,
  output logic                 last_out,
  output logic                 overflow
);

  localparam int unsigned PW = 2 * WIDTH_IN;

  logic signed [WIDTH_IN-1:0] a_q;
  logic                       v_q;
  logic                       l_q;
  logic signed [PW-1:0]       sq_s;
  logic [PW-1:0]              sq;
  logic [PW-1:0]              p_acc;
  logic                       v_acc;
  logic                       l_acc;
  logic                       newvec_q;
  logic [WIDTH_ACC-1:0]       base_c;
  logic [WIDTH_ACC:0]         sum_c;
  logic                       ovf_c;
  logic                       sticky_c;
  logic [WIDTH_ACC-1:0]       acc_nxt_c;

  // Stage 0: sample data is captured every edge, flags are cleared by reset
  always_ff @(posedge clk) begin
    a_q <= a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      l_q <= 1'b0;
    end else begin
      v_q <= valid_in;
      l_q <= last_in;
    end
  end

  // A square is never negative, so the signed product reinterprets losslessly
  assign sq_s = PW'(a_q) * PW'(a_q);
  assign sq   = $unsigned(sq_s);

  generate
    if (MULT_STAGES == 0) begin : g_comb
      assign p_acc = sq;
      assign v_acc = v_q;
      assign l_acc = l_q;
    end else begin : g_pipe
      logic [PW-1:0]          p_reg [MULT_STAGES];
      logic [MULT_STAGES-1:0] v_reg;
      logic [MULT_STAGES-1:0] l_reg;

      always_ff @(posedge clk) begin
        p_reg[0] <= sq;
        for (int i = 1; i < int'(MULT_STAGES); i++) begin
          p_reg[i] <= p_reg[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          v_reg <= '0;
          l_reg <= '0;
        end else begin
          v_reg[0] <= v_q;
          l_reg[0] <= l_q;
          for (int i = 1; i < int'(MULT_STAGES); i++) begin
            v_reg[i] <= v_reg[i-1];
            l_reg[i] <= l_reg[i-1];
          end
        end
      end

      assign p_acc = p_reg[MULT_STAGES-1];
      assign v_acc = v_reg[MULT_STAGES-1];
      assign l_acc = l_reg[MULT_STAGES-1];
    end
  endgenerate

  // Accumulate step; f itself is the accumulator
  always_comb begin
    base_c    = newvec_q ? '0 : f;
    sum_c     = {1'b0, base_c} + (WIDTH_ACC+1)'(p_acc);
    ovf_c     = sum_c[WIDTH_ACC];
    sticky_c  = overflow & ~newvec_q;
    acc_nxt_c = sum_c[WIDTH_ACC-1:0];
    // Sticky overflow within the vector doubles as the "already clamped" state
    if ((SATURATE != 0) && (ovf_c || sticky_c)) begin
      acc_nxt_c = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f         <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      overflow  <= 1'b0;
      newvec_q  <= 1'b1;
    end else begin
      valid_out <= v_acc;
      last_out  <= v_acc & l_acc;
      if (v_acc) begin
        f        <= acc_nxt_c;
        overflow <= ovf_c | sticky_c;
        newvec_q <= l_acc;
      end
    end
  end

endmodule

// File: tb/tb_l2_sq_accum_param.sv
// Directed bench: default wrap instance (MULT_STAGES=1) and a saturating
// instance with MULT_STAGES=0, sharing clock and reset.
module tb_l2_sq_accum_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a1, a2;
  logic        v1, v2, l1, l2;
  logic [19:0] f1, f2;
  logic        vo1, vo2, lo1, lo2, ov1, ov2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  l2_sq_accum_param u_wrap (
    .clk(clk), .reset(reset), .a(a1), .valid_in(v1), .last_in(l1),
    .f(f1), .valid_out(vo1), .last_out(lo1), .overflow(ov1)
  );

  l2_sq_accum_param #(
    .WIDTH_IN(8), .WIDTH_ACC(20), .MULT_STAGES(0), .SATURATE(1)
  ) u_sat (
    .clk(clk), .reset(reset), .a(a2), .valid_in(v2), .last_in(l2),
    .f(f2), .valid_out(vo2), .last_out(lo2), .overflow(ov2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drv1(input logic v, input logic [7:0] a, input logic l);
    v1 = v; a1 = a; l1 = l;
  endtask

  task automatic drv2(input logic v, input logic [7:0] a, input logic l);
    v2 = v; a2 = a; l2 = l;
  endtask

  initial begin
    longint e;
    longint got [3];
    int     np;

    // Reset held with a live sample on the inputs
    reset = 1'b1;
    drv1(1'b1, 8'd5, 1'b0);
    drv2(1'b1, 8'd5, 1'b0);
    repeat (3) begin
      step();
      check("rst_f1", f1, 0);
      check("rst_vo1", vo1, 0);
      check("rst_f2", f2, 0);
      check("rst_vo2", vo2, 0);
    end
    reset = 1'b0;
    drv1(1'b0, 8'd5, 1'b0);
    drv2(1'b0, 8'd5, 1'b0);
    repeat (3) begin
      step();
      check("post_rst_f1", f1, 0);
      check("post_rst_vo1", vo1, 0);
      check("post_rst_lo1", lo1, 0);
      check("post_rst_ov1", ov1, 0);
      check("post_rst_vo2", vo2, 0);
    end

    // Framed vectors: {3,-4} then {2}
    drv1(1'b1, 8'd3, 1'b0);   step(); check("t2_lat0", vo1, 0);
    drv1(1'b1, 8'hFC, 1'b1);  step(); check("t2_lat1", vo1, 0);
    drv1(1'b1, 8'd2, 1'b1);   step();
    check("t2_v0", vo1, 1); check("t2_f0", f1, 9); check("t2_l0", lo1, 0);
    drv1(1'b0, 8'd0, 1'b0);   step();
    check("t2_v1", vo1, 1); check("t2_f1", f1, 25); check("t2_l1", lo1, 1);
    step();
    check("t2_v2", vo1, 1); check("t2_f2", f1, 4); check("t2_l2", lo1, 1);
    step();
    check("t2_idle", vo1, 0); check("t2_hold", f1, 4);

    // Valid gaps with garbage on idle cycles
    np = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      drv1(1'b1, 8'd1, 1'b0);
      else if (c == 2) drv1(1'b1, 8'd2, 1'b0);
      else if (c == 6) drv1(1'b1, 8'd3, 1'b1);
      else             drv1(1'b0, 8'($urandom), 1'($urandom));
      step();
      if (vo1) begin
        if (np < 3) got[np] = longint'(f1);
        np++;
      end
    end
    check("t3_pulses", np, 3);
    if (np >= 3) begin
      check("t3_f0", got[0], 1);
      check("t3_f1", got[1], 5);
      check("t3_f2", got[2], 14);
    end

    // Invalid-only cycles after a vector ending at 25
    drv1(1'b1, 8'd3, 1'b0);  step();
    drv1(1'b1, 8'd4, 1'b1);  step();
    drv1(1'b0, 8'd0, 1'b0);  step();
    step();
    check("t4_f", f1, 25); check("t4_last", lo1, 1);
    for (int c = 0; c < 20; c++) begin
      drv1(1'b0, 8'($urandom), 1'($urandom));
      step();
      check("t4_hold_f", f1, 25);
      check("t4_hold_vo", vo1, 0);
    end
    check("t4_ovf", ov1, 0);

    // Wrap overflow: 64 x (-128) then 1 closing the vector
    for (int i = 0; i < 67; i++) begin
      if (i < 64)       drv1(1'b1, 8'h80, 1'b0);
      else if (i == 64) drv1(1'b1, 8'd1, 1'b1);
      else              drv1(1'b0, 8'($urandom), 1'b0);
      step();
      if (i >= 2) begin
        e = (i - 1 <= 63) ? 16384 * longint'(i - 1) : ((i - 1 == 64) ? 0 : 1);
        check("t5_vo", vo1, 1);
        check("t5_f", f1, e);
        check("t5_ovf", ov1, (i - 1 >= 64) ? 1 : 0);
        check("t5_last", lo1, (i - 1 == 65) ? 1 : 0);
      end
    end
    drv1(1'b1, 8'd2, 1'b1);  step();
    drv1(1'b0, 8'd0, 1'b0);  step();
    step();
    check("t5_next_f", f1, 4); check("t5_next_ovf", ov1, 0); check("t5_next_last", lo1, 1);

    // Saturate, zero multiplier stages: two-cycle latency
    for (int i = 0; i < 66; i++) begin
      if (i < 64)       drv2(1'b1, 8'h80, 1'b0);
      else if (i == 64) drv2(1'b1, 8'd1, 1'b1);
      else              drv2(1'b0, 8'($urandom), 1'b0);
      step();
      if (i == 0) check("t6_lat", vo2, 0);
      else begin
        e = (i <= 63) ? 16384 * longint'(i) : 1048575;
        check("t6_vo", vo2, 1);
        check("t6_f", f2, e);
        check("t6_ovf", ov2, (i >= 64) ? 1 : 0);
        check("t6_last", lo2, (i == 65) ? 1 : 0);
      end
    end
    drv2(1'b1, 8'd2, 1'b1);  step();
    drv2(1'b0, 8'd0, 1'b0);  step();
    check("t6_next_f", f2, 4); check("t6_next_ovf", ov2, 0); check("t6_next_last", lo2, 1);

    // Reset with samples in flight: none may emerge afterwards
    drv1(1'b1, 8'd7, 1'b0);  step();
    drv1(1'b1, 8'd9, 1'b0);  step();
    reset = 1'b1;
    drv1(1'b0, 8'd0, 1'b0);  step();
    reset = 1'b0;
    repeat (5) begin
      step();
      check("mid_rst_vo", vo1, 0);
      check("mid_rst_f", f1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
